// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate unit: one 1-bit step per clock over a valid/ready
// request handshake, with result/carry/zero presented on a valid/ready done handshake.
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic [SHW-1:0]   shamt,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state, state_nx;
  logic [1:0]     op_q;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  acc_count;
  logic [WIDTH:0] stepped;

  // Rotates wrap modulo WIDTH; shifts clamp at WIDTH+1, since every step past
  // WIDTH only moves zeros and the final carry is already zero.
  function automatic logic [CW-1:0] eff_count(input logic [1:0] o, input logic [SHW-1:0] s);
    int n;
    n = 32'(s);
    if (!o[1]) n = n % WIDTH;
    else if (n > WIDTH + 1) n = WIDTH + 1;
    return CW'(n);
  endfunction

  // Returns {carry, value} after one 1-bit step.
  function automatic logic [WIDTH:0] step(input logic [1:0] o, input logic [WIDTH-1:0] r);
    logic [WIDTH:0] s;
    unique case (o)
      2'b00: s = {r[WIDTH-1], r[WIDTH-2:0], r[WIDTH-1]};
      2'b01: s = {r[0], r[0], r[WIDTH-1:1]};
      2'b10: s = {r[WIDTH-1], r[WIDTH-2:0], 1'b0};
      2'b11: s = {r[0], 1'b0, r[WIDTH-1:1]};
    endcase
    return s;
  endfunction

  assign acc_count = eff_count(op, shamt);
  assign stepped   = step(op_q, result);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    start_ready = 1'b0;
    done_valid  = 1'b0;
    busy        = 1'b0;
    case (state)
      IDLE: if (start_valid) state_nx = (acc_count == '0) ? DONE : BUSY;
      BUSY: if (cnt == CW'(1)) state_nx = DONE;
      DONE: if (done_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
    start_ready = (state == IDLE) && !rst;
    done_valid  = (state == DONE);
    busy        = (state != IDLE);
  end

  // Datapath: capture at accept, one step per BUSY cycle; flush leaves it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
      op_q   <= 2'b00;
      cnt    <= '0;
    end else if (!flush) begin
      if (state == IDLE && start_valid) begin
        result <= operand;
        carry  <= 1'b0;
        op_q   <= op;
        cnt    <= acc_count;
        if (acc_count == '0) zero <= (operand == '0);
      end else if (state == BUSY) begin
        result <= stepped[WIDTH-1:0];
        carry  <= stepped[WIDTH];
        cnt    <= cnt - CW'(1);
        if (cnt == CW'(1)) zero <= (stepped[WIDTH-1:0] == '0);
      end
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: directed transactions push expected
// result/flags/latency; a negedge monitor compares whenever done_valid is high.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [1:0] op = 2'b00;
  logic [7:0] operand = 8'h00;
  logic [4:0] shamt = 5'd0;
  logic       done_valid;
  logic       done_ready = 1'b1;
  logic [7:0] result;
  logic       carry;
  logic       zero;
  logic       busy;

  typedef struct {
    logic [7:0] r;
    logic       c;
    logic       z;
    int         lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  shift_sequencer #(.WIDTH(8), .SHW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .start_valid(start_valid), .start_ready(start_ready),
    .op(op), .operand(operand), .shamt(shamt),
    .done_valid(done_valid), .done_ready(done_ready),
    .result(result), .carry(carry), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: latency from accept to first done_valid, value checks on every done cycle.
  int k = 0;
  int acc_k = 0;
  bit seen = 0;
  always @(negedge clk) begin
    k++;
    if (!rst) begin
      if (start_valid && start_ready) begin
        acc_k = k;
        seen  = 0;
      end
      if (done_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: result 0x%0h with empty scoreboard", result);
        end else begin
          if (!seen) begin
            chk("latency", k - acc_k, q[0].lat);
            seen = 1;
          end
          chk("result", {24'd0, result}, {24'd0, q[0].r});
          chk("carry", {31'd0, carry}, {31'd0, q[0].c});
          chk("zero", {31'd0, zero}, {31'd0, q[0].z});
          if (done_ready) begin
            void'(q.pop_front());
            seen = 0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request; push the expectation only for transactions that should complete.
  task automatic issue(input logic [1:0] o, input logic [7:0] v, input logic [4:0] s,
                       input bit push, input logic [7:0] er, input logic ec,
                       input logic ez, input int lat);
    int n = 0;
    while (!start_ready && n < 50) begin
      tick();
      n++;
    end
    if (!start_ready) chk("start_ready_timeout", 0, 1);
    op = o; operand = v; shamt = s; start_valid = 1'b1;
    if (push) q.push_back('{er, ec, ez, lat});
    tick();
    start_valid = 1'b0;
    operand = 8'hA5; shamt = 5'd7; op = 2'b01;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain_pending", q.size(), 0);
  endtask

  initial begin
    #3;
    chk("rst_start_ready", start_ready, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_carry", carry, 0);
    chk("rst_zero", zero, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("idle_start_ready", start_ready, 1);

    // ROL 0x81 by 1: done at T+2, ready again at T+3
    issue(2'b00, 8'h81, 5'd1, 1, 8'h03, 1'b1, 1'b0, 2);
    chk("rol_t1_done_valid", done_valid, 0);
    chk("rol_t1_busy", busy, 1);
    tick();
    chk("rol_t2_done_valid", done_valid, 1);
    tick();
    chk("rol_t3_start_ready", start_ready, 1);

    issue(2'b01, 8'h01, 5'd11, 1, 8'h20, 1'b0, 1'b0, 4);
    wait_drain();
    issue(2'b00, 8'h5A, 5'd16, 1, 8'h5A, 1'b0, 1'b0, 1);
    wait_drain();
    issue(2'b10, 8'hFF, 5'd8, 1, 8'h00, 1'b1, 1'b1, 9);
    wait_drain();
    issue(2'b11, 8'hFF, 5'd31, 1, 8'h00, 1'b0, 1'b1, 10);
    wait_drain();
    issue(2'b11, 8'h00, 5'd0, 1, 8'h00, 1'b0, 1'b1, 1);
    wait_drain();

    // Backpressure: SHR 0x80 by 3 held for 5 cycles, stray start ignored
    done_ready = 1'b0;
    issue(2'b11, 8'h80, 5'd3, 1, 8'h10, 1'b0, 1'b0, 4);
    begin
      int n = 0;
      while (!done_valid && n < 20) begin
        tick();
        n++;
      end
    end
    chk("bp_done_valid", done_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_start_ready", start_ready, 0);
      start_valid = (i == 2);
      op = 2'b00; operand = 8'hFF; shamt = 5'd1;
      tick();
    end
    start_valid = 1'b0;
    done_ready = 1'b1;
    tick();
    chk("bp_release_done_valid", done_valid, 0);
    chk("bp_release_start_ready", start_ready, 1);
    wait_drain();

    // Flush during ROL 0x01 by 6
    issue(2'b00, 8'h01, 5'd6, 0, 8'h00, 1'b0, 1'b0, 0);
    tick();
    chk("flush_busy_before", busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_done_valid", done_valid, 0);
    chk("flush_start_ready", start_ready, 1);
    repeat (8) tick();
    issue(2'b00, 8'h01, 5'd1, 1, 8'h02, 1'b0, 1'b0, 2);
    wait_drain();

    // Async reset mid-BUSY
    issue(2'b10, 8'h81, 5'd5, 0, 8'h00, 1'b0, 1'b0, 0);
    tick();
    chk("arst_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done_valid", done_valid, 0);
    chk("arst_result", result, 0);
    chk("arst_carry", carry, 0);
    chk("arst_start_ready", start_ready, 0);
    tick();
    rst = 1'b0;
    repeat (12) tick();
    issue(2'b10, 8'h81, 5'd1, 1, 8'h02, 1'b1, 1'b0, 2);
    wait_drain();
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle shift/rotate unit for the 8-bit ALU. It accepts one operation per transaction over a valid/ready handshake.
- It iterates a 1-bit rotate/shift step per clock for the effective shift count, then presents the result, carry and zero flags on a valid/ready output handshake.
- Sits between the instruction decode/ALU-op dispatch and the flag/register writeback path. It replaces single-cycle wide shifters on timing-critical builds.

Parameters:
- WIDTH, 8, operand/result width (only 8 is required to be verified).
- SHW, 5, shamt width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous abort; returns to IDLE, drops any in-flight result.
- start_valid  input  1  request valid.
- start_ready  output  1  unit can accept a request.
- op  input  2  00 ROL, 01 ROR, 10 SHL (logical), 11 SHR (logical).
- operand  input  WIDTH  value to shift.
- shamt  input  SHW  requested shift amount.
- done_valid  output  1  result/flags valid.
- done_ready  input  1  consumer accepts result.
- result  output  WIDTH  shifted value.
- carry  output  1  last bit shifted/rotated across the boundary.
- zero  output  1  result == 0.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; result=0, carry=0, zero=0, done_valid=0, busy=0.
  - start_ready=0 while rst is high, 1 in IDLE otherwise.
- States: IDLE, BUSY, DONE.
  - start_ready = (state==IDLE).
  - done_valid = (state==DONE).
  - busy = (state!=IDLE).
- Accept: start_valid & start_ready at edge T.
  - Latch op and operand into the result register; clear carry.
  - Load the step counter with the effective count N:
    - Rotates: N = shamt mod 8 (shamt[2:0]).
    - Shifts: N = min(shamt, 9). Steps beyond 8 shift out zeros, so clamping to 9 preserves the result and carry.
  - N==0: go to DONE at T+1 with result=operand, carry=0.
  - N>0: go to BUSY.
- BUSY, each cycle applies one step and decrements the counter:
  - ROL: result={result[6:0],result[7]}, carry=result[7].
  - ROR: result={result[0],result[7:1]}, carry=result[0].
  - SHL: result={result[6:0],0}, carry=result[7].
  - SHR: result={0,result[7:1]}, carry=result[0].
  - When the counter reaches 0, go to DONE. done_valid rises at T+1+N.
- zero is registered together with the final result.
- DONE:
  - result, carry and zero hold stable until done_ready=1. Then go to IDLE at the next edge.
  - No new request is accepted in the same cycle as the DONE handshake; minimum issue interval is N+2 cycles.
- Outside DONE, result/carry/zero keep their last values. Consumers must qualify them with done_valid.
- start_valid while not ready is ignored; it is neither latched nor queued.
- Input changes during BUSY/DONE have no effect. op and operand are captured only at accept.
- Flush:
  - flush=1 in any state returns to IDLE at the next edge with done_valid=0. result/carry/zero are left unchanged.
  - flush has priority over accept and over the DONE handshake.
- Reset mid-BUSY/DONE returns immediately to reset values; no done is produced.

Test Plan:
- ROL operand=0x81, shamt=1, done_ready=1 → done_valid at T+2; result=0x03, carry=1, zero=0; start_ready back to 1 at T+3.
- ROR operand=0x01, shamt=11 (effective 3) → done_valid at T+4; result=0x20, carry=0. Also ROL 0x5A shamt=16 → done at T+1, result=0x5A, carry=0.
- SHL operand=0xFF, shamt=8 → done at T+9, result=0x00, carry=1, zero=1. SHR operand=0xFF, shamt=31 → done at T+10, result=0x00, carry=0, zero=1.
- Backpressure: SHR 0x80 by 3 with done_ready=0 for 5 cycles → result=0x10 and carry=0 held stable. start_ready=0; a start_valid pulse during this window is ignored. Raising done_ready returns the unit to IDLE next cycle.
- Flush at T+2 during ROL 0x01 by 6 → IDLE at T+3, done_valid never asserts, start_ready=1 at T+3. A new ROL 0x01 by 1 then yields 0x02.
- Async rst pulse mid-BUSY (between edges) → busy, done_valid, result and carry go to 0 without waiting for a clock edge. After release, a normal transaction completes correctly.
